// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED blink-code arbiter slice.
package led_ctrl_pkg;

   // Width of a blink code (flash count) supplied by each requester
   localparam int CODE_W = 4;

   // Default timing, kept small so a short simulation shows complete codes
   localparam int DEF_TICK_DIV  = 4;
   localparam int DEF_ON_TICKS  = 2;
   localparam int DEF_OFF_TICKS = 2;
   localparam int DEF_GAP_TICKS = 4;

   // Flash-sequencing FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      GAP  = 2'd3
   } led_state_t;

   // Largest of three tick counts, used to size the phase counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/led_code_arbiter_if.sv
// Request/grant and LED status bundle between the requesters and the arbiter.
interface led_code_arbiter_if;
   import led_ctrl_pkg::*;

   logic [1:0]        req;
   logic [CODE_W-1:0] code0;
   logic [CODE_W-1:0] code1;
   logic [1:0]        gnt;
   logic              led;
   logic              busy;
   logic              done;

   // Requester side: raises requests and codes, watches grant and status
   modport master (
      output req, code0, code1,
      input  gnt, led, busy, done
   );

   // Arbiter side: consumes requests and codes, drives grant, LED and status
   modport slave (
      input  req, code0, code1,
      output gnt, led, busy, done
   );

endinterface

// File: rtl/led_tick_gen.sv
// Timing-tick prescaler: one tick every TICK_DIV clocks, restartable with clr.
module led_tick_gen #(
   parameter int TICK_DIV = led_ctrl_pkg::DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] tick_cnt;

   // Free-running 0..TICK_DIV-1 counter; clr realigns it to the start of a code
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tick_cnt <= '0;
      end else if (tick_cnt == LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + CW'(1);
      end
   end

   assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/led_code_arbiter.sv
// Shares one LED between two requesters, each showing an N-flash blink code
// followed by a dark gap. Round-robin arbitration on ties.
module led_code_arbiter
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int ON_TICKS  = DEF_ON_TICKS,
   parameter int OFF_TICKS = DEF_OFF_TICKS,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic               clk,
   input  logic               rst,
   led_code_arbiter_if.slave  bus
);

   localparam int            PHASE_MAX = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
   localparam int            PW        = $clog2(PHASE_MAX) + 1;
   localparam logic [PW-1:0] ON_LAST   = PW'(ON_TICKS - 1);
   localparam logic [PW-1:0] OFF_LAST  = PW'(OFF_TICKS - 1);
   localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_TICKS - 1);

   led_state_t        state;
   logic [1:0]        gnt_q;
   logic              led_q;
   logic              busy_q;
   logic              done_q;
   logic              rr_last;
   logic [CODE_W-1:0] remaining;
   logic [PW-1:0]     phase_cnt;

   logic              tick;
   logic              arb_en;
   logic              win_valid;
   logic              win_idx;
   logic [1:0]        win_onehot;
   logic [CODE_W-1:0] win_code;
   logic              grant;
   logic [PW-1:0]     phase_last;
   logic              phase_end;

   // Prescaler restarts on every grant so each code begins on a tick boundary
   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (grant),
      .tick (tick)
   );

   // Pick a winner in IDLE. Arbitration is held off while a grant pulse is
   // still visible, because the requester only drops req after seeing it;
   // otherwise a zero-length code would be granted twice.
   always_comb begin
      arb_en    = (state == IDLE) && (gnt_q == 2'b00);
      win_valid = 1'b0;
      win_idx   = 1'b0;
      case (bus.req)
         2'b01: begin
            win_valid = 1'b1;
            win_idx   = 1'b0;
         end
         2'b10: begin
            win_valid = 1'b1;
            win_idx   = 1'b1;
         end
         2'b11: begin
            win_valid = 1'b1;
            win_idx   = ~rr_last;
         end
         default: begin
            win_valid = 1'b0;
            win_idx   = 1'b0;
         end
      endcase
      win_onehot = win_idx ? 2'b10 : 2'b01;
      win_code   = win_idx ? bus.code1 : bus.code0;
      grant      = arb_en && win_valid;
   end

   // Tick count that ends the current phase, and whether this tick ends it
   always_comb begin
      phase_last = ON_LAST;
      case (state)
         ON:      phase_last = ON_LAST;
         OFF:     phase_last = OFF_LAST;
         GAP:     phase_last = GAP_LAST;
         default: phase_last = ON_LAST;
      endcase
      phase_end = tick && (phase_cnt == phase_last);
   end

   // Flash-sequencing FSM with registered grant, LED and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_q     <= 2'b00;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rr_last   <= 1'b0;
         remaining <= '0;
         phase_cnt <= '0;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  gnt_q     <= win_onehot;
                  rr_last   <= win_idx;
                  remaining <= win_code;
                  phase_cnt <= '0;
                  if (win_code != '0) begin
                     state  <= ON;
                     led_q  <= 1'b1;
                     busy_q <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ON: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  state     <= OFF;
                  led_q     <= 1'b0;
                  if (remaining != '0) begin
                     remaining <= remaining - CODE_W'(1);
                  end
               end else if (tick) begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            OFF: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  if (remaining == '0) begin
                     state <= GAP;
                  end else begin
                     state <= ON;
                     led_q <= 1'b1;
                  end
               end else if (tick) begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            GAP: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  state     <= IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else if (tick) begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.led  = led_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_led_code_arbiter.sv
// Directed bench for led_code_arbiter with default timing parameters.
module tb_led_code_arbiter;
   import led_ctrl_pkg::*;

   localparam int TD    = 4;
   localparam int ONT   = 2;
   localparam int OFFT  = 2;
   localparam int GAPT  = 4;
   localparam int FLASH = TD * (ONT + OFFT);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;
   logic [4:0] obs;
   logic [4:0] exp_v;

   led_code_arbiter_if bus ();

   led_code_arbiter #(
      .TICK_DIV  (TD),
      .ON_TICKS  (ONT),
      .OFF_TICKS (OFFT),
      .GAP_TICKS (GAPT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycles from grant to done for an n-flash code
   function automatic int dur(input int n);
      return TD * (n * (ONT + OFFT) + GAPT);
   endfunction

   // Expected {gnt, led, busy, done} t cycles after the grant cycle
   function automatic logic [4:0] exp_vec(input int n, input int t, input logic [1:0] g);
      logic [1:0] eg;
      logic       el, eb, ed;
      eg = (t == 0) ? g : 2'b00;
      if (n == 0) begin
         el = 1'b0;
         eb = 1'b0;
         ed = (t == 0);
      end else begin
         el = (t < n * FLASH) && ((t % FLASH) < TD * ONT);
         eb = (t < dur(n));
         ed = (t == dur(n));
      end
      return {eg, el, eb, ed};
   endfunction

   // Advance one clock and settle past the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req   = 2'b00;
      bus.code0 = '0;
      bus.code1 = '0;
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt got %b expected 00", bus.gnt); end
      checks++;
      if (bus.led !== 1'b0) begin errors++; $display("[TB] FAIL reset_led got %b expected 0", bus.led); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", bus.done); end
      rst = 1'b0;
      step();
      obs = {bus.gnt, bus.led, bus.busy, bus.done};
      checks++;
      if (obs !== 5'b0) begin errors++; $display("[TB] FAIL idle_quiet got %b expected 00000", obs); end
   endtask

   task automatic test_single();
      bus.code0 = 4'd3;
      bus.req   = 2'b01;
      step();
      for (int t = 0; t <= dur(3) + 1; t++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(3, t, 2'b01);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL single t=%0d got %b expected %b", t, obs, exp_v);
         end
         if (t == 0) bus.req = 2'b00;
         step();
      end
   endtask

   task automatic test_tie();
      do_reset();
      bus.code0 = 4'd1;
      bus.code1 = 4'd2;
      bus.req   = 2'b11;
      step();
      for (int t = 0; t <= dur(2); t++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(2, t, 2'b10);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL tie_first t=%0d got %b expected %b", t, obs, exp_v);
         end
         if (t == 0) bus.req = 2'b01;
         step();
      end
      for (int u = 0; u <= dur(1) + 1; u++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(1, u, 2'b01);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL tie_second u=%0d got %b expected %b", u, obs, exp_v);
         end
         if (u == 0) bus.req = 2'b00;
         step();
      end
   endtask

   task automatic test_zero_code();
      bus.code1 = 4'd0;
      bus.req   = 2'b10;
      step();
      obs = {bus.gnt, bus.led, bus.busy, bus.done};
      checks++;
      if (obs !== 5'b10001) begin errors++; $display("[TB] FAIL zero_grant got %b expected 10001", obs); end
      bus.req = 2'b00;
      for (int t = 1; t <= 3; t++) begin
         step();
         obs = {bus.gnt, bus.led, bus.busy, bus.done};
         checks++;
         if (obs !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL zero_after t=%0d got %b expected 00000", t, obs);
         end
      end
   endtask

   task automatic test_busy_request();
      bus.code1 = 4'd2;
      bus.req   = 2'b10;
      step();
      for (int t = 0; t <= dur(2) + 2; t++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(2, t, 2'b10);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL busy_req t=%0d got %b expected %b", t, obs, exp_v);
         end
         if (t == 0)  bus.req = 2'b00;
         if (t == 2)  bus.req = 2'b01;
         if (t == 40) bus.req = 2'b00;
         step();
      end
   endtask

   task automatic test_mid_reset();
      bus.code1 = 4'd3;
      bus.req   = 2'b10;
      step();
      for (int t = 0; t < 18; t++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(3, t, 2'b10);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL midrst_pre t=%0d got %b expected %b", t, obs, exp_v);
         end
         if (t == 0) bus.req = 2'b00;
         step();
      end
      checks++;
      if (bus.led !== 1'b1) begin errors++; $display("[TB] FAIL midrst_second_flash got %b expected 1", bus.led); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int t = 0; t < 80; t++) begin
         obs = {bus.gnt, bus.led, bus.busy, bus.done};
         checks++;
         if (obs !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL midrst_quiet t=%0d got %b expected 00000", t, obs);
         end
         step();
      end
      bus.code0 = 4'd1;
      bus.code1 = 4'd1;
      bus.req   = 2'b11;
      step();
      for (int u = 0; u <= dur(1) + 1; u++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(1, u, 2'b10);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL midrst_tie u=%0d got %b expected %b", u, obs, exp_v);
         end
         if (u == 0) bus.req = 2'b00;
         step();
      end
   endtask

   task automatic test_code_latch();
      bus.code0 = 4'd2;
      bus.req   = 2'b01;
      step();
      for (int t = 0; t <= dur(2) + FLASH; t++) begin
         obs   = {bus.gnt, bus.led, bus.busy, bus.done};
         exp_v = exp_vec(2, t, 2'b01);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL code_latch t=%0d got %b expected %b", t, obs, exp_v);
         end
         if (t == 0) bus.req = 2'b00;
         if (t == 1) bus.code0 = 4'd5;
         step();
      end
   endtask

   // Scenario sequence
   initial begin
      bus.req   = 2'b00;
      bus.code0 = '0;
      bus.code1 = '0;
      test_reset();
      test_single();
      test_tie();
      test_zero_code();
      test_busy_request();
      test_mid_reset();
      test_code_latch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
